// File: rtl/stopwatch_tick_counter.sv
// stopwatch_tick_counter
//   Synchronizes a slow divided clock (tick_in) into clock_in, turns each rising
//   edge into a one-cycle tick enable, and counts those ticks into a BCD MM:SS
//   stopwatch under start/stop/clear control.
//   Optional feature: define LAP_CAPTURE_EN to add the lap port and lap-freeze of
//   the displayed digits. Without it the outputs always show the live count.
module stopwatch_tick_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN     = 59
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
`ifdef LAP_CAPTURE_EN
  input  logic       lap,
`endif
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       tick_pulse,
  output logic       wrap
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

  // One BCD digit step: returns {carry, next}. Any value at or above the limit
  // rolls to zero, so a digit can never leave the legal BCD range.
  function automatic logic [4:0] bcd_inc(input logic [3:0] digit, input logic [3:0] limit);
    logic [4:0] res;
    if (digit >= limit) begin
      res = {1'b1, 4'd0};
    end else begin
      res = {1'b0, digit + 4'd1};
    end
    return res;
  endfunction

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   history_r;
  logic                   tick_pulse_r;
  logic [1:0]             state_r;
  logic [1:0]             state_s;
  logic                   running_r;
  logic [3:0]             sec_ones_r, sec_tens_r, min_ones_r, min_tens_r;
  logic [3:0]             sec_ones_s, sec_tens_s, min_ones_s, min_tens_s;
  logic                   wrap_r;
  logic                   wrap_s;
  logic                   sync_out_s;
  logic                   count_en_s;
  logic                   at_max_s;
  logic [4:0]             so_inc_s, st_inc_s, mo_inc_s, mt_inc_s;

  assign sync_out_s = sync_r[SYNC_STAGES-1];
  assign count_en_s = tick_pulse_r && (state_r == ST_RUN);
  assign at_max_s   = (min_tens_r == MAX_TENS) && (min_ones_r == MAX_ONES) &&
                      (sec_tens_r == 4'd5) && (sec_ones_r == 4'd9);
  assign so_inc_s   = bcd_inc(sec_ones_r, 4'd9);
  assign st_inc_s   = bcd_inc(sec_tens_r, 4'd5);
  assign mo_inc_s   = bcd_inc(min_ones_r, 4'd9);
  assign mt_inc_s   = bcd_inc(min_tens_r, 4'd5);

  // Synchronizer chain, edge history and registered rising-edge pulse.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_r       <= '0;
      history_r    <= 1'b0;
      tick_pulse_r <= 1'b0;
    end else begin
      sync_r       <= {sync_r[SYNC_STAGES-2:0], tick_in};
      history_r    <= sync_out_s;
      tick_pulse_r <= sync_out_s & ~history_r;
    end
  end

  // Next FSM state; clear beats stop, stop only acts in RUN, start only outside RUN.
  always_comb begin
    state_s = state_r;
    if (clear) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (stop) state_s = ST_PAUSE;
          else      state_s = ST_RUN;
        end
        ST_IDLE, ST_PAUSE: begin
          if (start) state_s = ST_RUN;
          else       state_s = state_r;
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Next BCD count: clear wins, otherwise advance with a combinational carry chain.
  always_comb begin
    sec_ones_s = sec_ones_r;
    sec_tens_s = sec_tens_r;
    min_ones_s = min_ones_r;
    min_tens_s = min_tens_r;
    wrap_s     = 1'b0;
    if (clear) begin
      sec_ones_s = 4'd0;
      sec_tens_s = 4'd0;
      min_ones_s = 4'd0;
      min_tens_s = 4'd0;
    end else if (count_en_s) begin
      if (at_max_s) begin
        sec_ones_s = 4'd0;
        sec_tens_s = 4'd0;
        min_ones_s = 4'd0;
        min_tens_s = 4'd0;
        wrap_s     = 1'b1;
      end else begin
        sec_ones_s = so_inc_s[3:0];
        sec_tens_s = so_inc_s[4] ? st_inc_s[3:0] : sec_tens_r;
        min_ones_s = (so_inc_s[4] && st_inc_s[4]) ? mo_inc_s[3:0] : min_ones_r;
        min_tens_s = (so_inc_s[4] && st_inc_s[4] && mo_inc_s[4]) ? mt_inc_s[3:0] : min_tens_r;
      end
    end else begin
      wrap_s = 1'b0;
    end
  end

  // State, running flag, count digits and wrap pulse registers.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      running_r  <= 1'b0;
      sec_ones_r <= 4'd0;
      sec_tens_r <= 4'd0;
      min_ones_r <= 4'd0;
      min_tens_r <= 4'd0;
      wrap_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      running_r  <= (state_s == ST_RUN);
      sec_ones_r <= sec_ones_s;
      sec_tens_r <= sec_tens_s;
      min_ones_r <= min_ones_s;
      min_tens_r <= min_tens_s;
      wrap_r     <= wrap_s;
    end
  end

  assign running    = running_r;
  assign tick_pulse = tick_pulse_r;
  assign wrap       = wrap_r;

`ifdef LAP_CAPTURE_EN
  logic        lap_hist_r;
  logic        freeze_r;
  logic [15:0] lap_time_r;
  logic        lap_rise_s;

  assign lap_rise_s = lap & ~lap_hist_r;

  // Lap freeze: first lap edge in RUN captures the display, next edge, stop or clear releases it.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      lap_hist_r <= 1'b0;
      freeze_r   <= 1'b0;
      lap_time_r <= 16'd0;
    end else begin
      lap_hist_r <= lap;
      if (clear || stop) begin
        freeze_r <= 1'b0;
      end else if (lap_rise_s && freeze_r) begin
        freeze_r <= 1'b0;
      end else if (lap_rise_s && (state_r == ST_RUN)) begin
        freeze_r   <= 1'b1;
        lap_time_r <= {min_tens_r, min_ones_r, sec_tens_r, sec_ones_r};
      end
    end
  end

  assign min_tens = freeze_r ? lap_time_r[15:12] : min_tens_r;
  assign min_ones = freeze_r ? lap_time_r[11:8]  : min_ones_r;
  assign sec_tens = freeze_r ? lap_time_r[7:4]   : sec_tens_r;
  assign sec_ones = freeze_r ? lap_time_r[3:0]   : sec_ones_r;
`else
  assign min_tens = min_tens_r;
  assign min_ones = min_ones_r;
  assign sec_tens = sec_tens_r;
  assign sec_ones = sec_ones_r;
`endif

endmodule

// File: tb/tb_stopwatch_tick_counter.sv
// Directed bench for stopwatch_tick_counter: a vector table for the control and
// counting steps plus hand sequences for tick alignment, wrap, and reset.
module tb_stopwatch_tick_counter;
  localparam int SYNC_STAGES = 2;
  localparam int MAX_MIN     = 59;

  logic       clock_in = 1'b0;
  logic       reset_n  = 1'b0;
  logic       tick_in  = 1'b0;
  logic       start    = 1'b0;
  logic       stop     = 1'b0;
  logic       clear    = 1'b0;
`ifdef LAP_CAPTURE_EN
  logic       lap      = 1'b0;
`endif
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, tick_pulse, wrap;

  int checks    = 0;
  int failures  = 0;
  int wrap_cnt  = 0;
  int pulse_cnt = 0;

  typedef struct {
    logic        start;
    logic        stop;
    logic        clear;
    int          nticks;
    logic [15:0] exp_time;
    logic        exp_run;
    int          exp_wraps;
    string       name;
  } vec_t;

  vec_t vecs[11];

  always #10 clock_in = ~clock_in;

  stopwatch_tick_counter #(
    .SYNC_STAGES(SYNC_STAGES),
    .MAX_MIN    (MAX_MIN)
  ) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .tick_in   (tick_in),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
`ifdef LAP_CAPTURE_EN
    .lap       (lap),
`endif
    .sec_ones  (sec_ones),
    .sec_tens  (sec_tens),
    .min_ones  (min_ones),
    .min_tens  (min_tens),
    .running   (running),
    .tick_pulse(tick_pulse),
    .wrap      (wrap)
  );

  // Count one-cycle pulses shortly after each active edge.
  always @(posedge clock_in) begin
    #1;
    if (wrap === 1'b1) wrap_cnt++;
    if (tick_pulse === 1'b1) pulse_cnt++;
  end

  function automatic logic [15:0] now_time();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One full tick_in period; optionally checks tick_pulse position after each edge.
  task automatic send_tick(input bit timed);
    @(negedge clock_in);
    tick_in = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + 2; k++) begin
      @(negedge clock_in);
      if (timed) chk("pulse_timing", {31'd0, tick_pulse}, {31'd0, (k == SYNC_STAGES + 1)});
    end
    tick_in = 1'b0;
    repeat (SYNC_STAGES + 2) @(negedge clock_in);
  endtask

  // Raise tick_in and stop at the negedge where tick_pulse is high.
  task automatic tick_to_pulse();
    @(negedge clock_in);
    tick_in = 1'b1;
    repeat (SYNC_STAGES + 1) @(negedge clock_in);
    chk("pulse_align", {31'd0, tick_pulse}, 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clock_in);
    start = 1'b1;
    @(negedge clock_in);
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_t;
    int p0;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 49,  16'h0059, 1'b1, 0, "run_to_0059"};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1,   16'h0100, 1'b1, 0, "carry_0100"};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 0,   16'h0100, 1'b0, 0, "stop_pause"};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 3,   16'h0100, 1'b0, 0, "pause_hold"};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1,   16'h0101, 1'b1, 0, "resume_tick"};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 0,   16'h0101, 1'b1, 0, "start_in_run"};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 0,   16'h0101, 1'b0, 0, "stop_again"};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 0,   16'h0101, 1'b0, 0, "stop_in_pause"};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 0,   16'h0000, 1'b0, 0, "clear_idle"};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 5,   16'h0000, 1'b0, 0, "idle_no_count"};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 133, 16'h0213, 1'b1, 0, "run_to_0213"};

    // Reset held with tick_in toggling: everything stays zero.
    for (int i = 0; i < 12; i++) begin
      @(negedge clock_in);
      tick_in = ~tick_in;
      chk("reset_outputs", {13'd0, now_time(), running, tick_pulse, wrap}, 32'd0);
    end
    tick_in = 1'b0;
    @(negedge clock_in);
    reset_n = 1'b1;
    repeat (SYNC_STAGES + 3) @(negedge clock_in);
    chk("post_reset_time", now_time(), 16'h0000);
    chk("post_reset_running", running, 1'b0);
    chk("post_reset_pulses", pulse_cnt, 0);

    // Start and ten timed ticks.
    pulse_start();
    chk("start_running", running, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      send_tick(1'b1);
      exp_t = {8'h00, 4'(i / 10), 4'(i % 10)};
      chk("ten_ticks_time", now_time(), exp_t);
    end
    chk("ten_ticks_running", running, 1'b1);
    chk("ten_ticks_pulses", pulse_cnt, 10);

    // Table of control/count steps.
    for (int v = 0; v < 11; v++) begin
      @(negedge clock_in);
      start = vecs[v].start;
      stop  = vecs[v].stop;
      clear = vecs[v].clear;
      @(negedge clock_in);
      start = 1'b0;
      stop  = 1'b0;
      clear = 1'b0;
      repeat (vecs[v].nticks) send_tick(1'b0);
      @(negedge clock_in);
      chk({vecs[v].name, "_time"}, now_time(), vecs[v].exp_time);
      chk({vecs[v].name, "_run"}, running, vecs[v].exp_run);
      chk({vecs[v].name, "_wraps"}, wrap_cnt, vecs[v].exp_wraps);
    end

    // clear + start + tick in the same cycle at 02:13.
    tick_to_pulse();
    clear = 1'b1;
    start = 1'b1;
    @(negedge clock_in);
    clear = 1'b0;
    start = 1'b0;
    chk("clear_tick_time", now_time(), 16'h0000);
    chk("clear_tick_running", running, 1'b0);
    tick_in = 1'b0;
    repeat (SYNC_STAGES + 2) @(negedge clock_in);
    chk("clear_tick_later", now_time(), 16'h0000);

    // stop and tick together at 00:05.
    pulse_start();
    repeat (5) send_tick(1'b0);
    chk("pre_stop_time", now_time(), 16'h0005);
    tick_to_pulse();
    stop = 1'b1;
    @(negedge clock_in);
    stop = 1'b0;
    chk("stop_tick_time", now_time(), 16'h0006);
    chk("stop_tick_running", running, 1'b0);
    tick_in = 1'b0;
    repeat (SYNC_STAGES + 2) @(negedge clock_in);
    repeat (3) send_tick(1'b0);
    chk("paused_time", now_time(), 16'h0006);
    pulse_start();
    send_tick(1'b0);
    chk("resumed_time", now_time(), 16'h0007);
    chk("resumed_running", running, 1'b1);

    // Held-high tick_in produces exactly one pulse.
    p0 = pulse_cnt;
    @(negedge clock_in);
    tick_in = 1'b1;
    repeat (20) @(negedge clock_in);
    chk("held_high_pulses", pulse_cnt - p0, 1);
    chk("held_high_time", now_time(), 16'h0008);
    tick_in = 1'b0;
    repeat (SYNC_STAGES + 2) @(negedge clock_in);

    // Run up to 59:59, then wrap.
    repeat (3591) send_tick(1'b0);
    chk("max_time", now_time(), 16'h5959);
    chk("max_wraps", wrap_cnt, 0);
    @(negedge clock_in);
    tick_in = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + 3; k++) begin
      @(negedge clock_in);
      chk("wrap_pulse", {31'd0, wrap}, {31'd0, (k == SYNC_STAGES + 2)});
      if (k == SYNC_STAGES + 2) begin
        chk("wrap_time", now_time(), 16'h0000);
        chk("wrap_running", running, 1'b1);
      end
    end
    tick_in = 1'b0;
    repeat (SYNC_STAGES + 2) @(negedge clock_in);
    chk("wrap_count", wrap_cnt, 1);

    // Asynchronous reset mid-run clears immediately.
    repeat (3) send_tick(1'b0);
    chk("pre_async_time", now_time(), 16'h0003);
    @(negedge clock_in);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {13'd0, now_time(), running, tick_pulse, wrap}, 32'd0);
    @(negedge clock_in);
    reset_n = 1'b1;
    @(negedge clock_in);
    chk("after_async_running", running, 1'b0);

`ifdef LAP_CAPTURE_EN
    // Lap freeze at 00:20, release at 00:25.
    pulse_start();
    repeat (20) send_tick(1'b0);
    @(negedge clock_in);
    lap = 1'b1;
    @(negedge clock_in);
    lap = 1'b0;
    chk("lap_capture", now_time(), 16'h0020);
    repeat (5) send_tick(1'b0);
    chk("lap_hold", now_time(), 16'h0020);
    @(negedge clock_in);
    lap = 1'b1;
    @(negedge clock_in);
    lap = 1'b0;
    chk("lap_release", now_time(), 16'h0025);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
